// File: rtl/ext_queue.sv
// ext_queue: immediate-extension unit feeding a DEPTH-entry result queue.
// Extension happens on the way in; the queue absorbs downstream stalls.
// Optional feature macro: EXT_BYPASS_EN. When it is defined, an empty queue
// forwards the extended input straight to the output in the same cycle.
// Handshake contract (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A producer holds its payload stable while
// valid=1 and ready=0. in_ready is derived only from registered state.
module ext_queue #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ill,
  output logic [7:0]       ill_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [OP_W-1:0] OP_ZERO   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SIGN   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_UPPER  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(3);

  // Storage and registered state
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic             ill_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       ill_cnt_q, ill_cnt_d;

  logic [OUT_W-1:0] ext_data;
  logic             ext_ill;
  logic [OUT_W-1:0] sext;
  logic             full, empty;
  logic             bypass;
  logic             push, pop;

  // Extend the incoming immediate according to the op code
  always_comb begin
    sext     = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    ext_data = '0;
    ext_ill  = 1'b0;
    case (in_op)
      OP_ZERO:   ext_data = {{PAD_W{1'b0}}, in_imm};
      OP_SIGN:   ext_data = sext;
      OP_UPPER:  ext_data = {in_imm, {PAD_W{1'b0}}};
      OP_BRANCH: ext_data = sext << 2;
      default:   ext_ill  = 1'b1;
    endcase
  end

  // Handshake decode, output mux and next-state computation
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
`ifdef EXT_BYPASS_EN
    bypass = empty & in_valid & out_ready;
`else
    bypass = 1'b0;
`endif
    in_ready  = !full;
    // A bypassed transfer is consumed directly and never enters the queue.
    push      = in_valid & in_ready & !bypass;
    pop       = !empty & out_ready;
    out_valid = !empty | bypass;

    out_data = '0;
    out_ill  = 1'b0;
    if (bypass) begin
      out_data = ext_data;
      out_ill  = ext_ill;
    end else if (!empty) begin
      out_data = mem_q[rd_ptr_q];
      out_ill  = ill_mem_q[rd_ptr_q];
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ill_cnt_d = ill_cnt_q;
    if ((push | bypass) & ext_ill & (ill_cnt_q != 8'hFF))
      ill_cnt_d = ill_cnt_q + 8'd1;
  end

  assign ill_cnt = ill_cnt_q;

  // Queue storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q]     <= ext_data;
      ill_mem_q[wr_ptr_q] <= ext_ill;
    end
  end

  // Pointer, occupancy and error-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_queue.sv
// tb_ext_queue: directed stimulus for ext_queue with an expected-result queue
// drained by an independent output monitor.
module tb_ext_queue;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int OP_W  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ill;
  logic [7:0]       ill_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // {ill, data} of every result still owed by the DUT, in order
  logic [OUT_W:0] exp_q[$];

  ext_queue #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(4), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ill(out_ill), .ill_cnt(ill_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data 'h%0h ill %0b with nothing expected",
                 out_data, out_ill);
      end else begin
        logic [OUT_W:0] e;
        e = exp_q.pop_front();
        if ({out_ill, out_data} !== e) begin
          n_fail++;
          $display("FAIL out_result: got ill %0b data 'h%0h expected ill %0b data 'h%0h",
                   out_ill, out_data, e[OUT_W], e[OUT_W-1:0]);
        end
      end
    end
  end

  // Driver: offer one item, hold it until accepted, return #1 after the accepting edge
  task automatic push_one(input logic [OP_W-1:0] op, input logic [IN_W-1:0] imm,
                          input logic [OUT_W-1:0] exp_data, input logic exp_ill);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    exp_q.push_back({exp_ill, exp_data});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected result has come out and the queue is empty
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {63'd0, out_valid}, 64'd0);
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data",  64'(out_data), 64'd0);
    check("rst_out_ill",   {63'd0, out_ill}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_ill_cnt",   64'(ill_cnt), 64'd0);

    // 1: SIGN 8000 visible one cycle after the push edge
    push_one(3'd1, 16'h8000, 32'hFFFF8000, 1'b0);
    check("t1_out_valid", {63'd0, out_valid}, 64'd1);
    check("t1_out_data",  64'(out_data), 64'hFFFF8000);
    check("t1_out_ill",   {63'd0, out_ill}, 64'd0);
    out_ready = 1'b1;
    drain("t1_drain");

    // 2: ZERO, UPPER, BRANCH back to back
    push_one(3'd0, 16'h8000, 32'h00008000, 1'b0);
    push_one(3'd2, 16'h1234, 32'h12340000, 1'b0);
    push_one(3'd3, 16'hFFFF, 32'hFFFFFFFC, 1'b0);
    push_one(3'd3, 16'h4001, 32'h00010004, 1'b0);
    drain("t2_drain");

    // 3: stall downstream, fill, hold the fifth item upstream, then release
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      push_one(3'd0, 16'(i), 32'(i), 1'b0);
    check("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
    fork
      push_one(3'd0, 16'd5, 32'd5, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("t3_hold_count", 64'(dut.count_q), 64'd4);
        check("t3_hold_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    drain("t3_drain");

    // 4: steady occupancy of 2 with push and pop every cycle
    out_ready = 1'b0;
    push_one(3'd0, 16'h0010, 32'h00000010, 1'b0);
    push_one(3'd0, 16'h0011, 32'h00000011, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_imm   = 16'(16'h0012 + i);
      exp_q.push_back({1'b0, 32'(32'h12 + i)});
      @(negedge clk);
      check("t4_count", 64'(dut.count_q), 64'd2);
      check("t4_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain("t4_drain");

    // 5: illegal ops produce zero with ill=1, counter saturates
    push_one(3'd5, 16'h1234, 32'd0, 1'b1);
    push_one(3'd7, 16'hFFFF, 32'd0, 1'b1);
    drain("t5_drain_a");
    check("t5_ill_cnt_2", 64'(ill_cnt), 64'd2);
    for (int i = 0; i < 300; i++)
      push_one(3'(4 + (i % 4)), 16'(i), 32'd0, 1'b1);
    drain("t5_drain_b");
    check("t5_ill_cnt_sat", 64'(ill_cnt), 64'd255);

    // 6: reset mid-stream beats a same-cycle push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_one(3'd0, 16'(16'h20 + i), 32'(32'h20 + i), 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd6;
    in_imm   = 16'h0042;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_count",     64'(dut.count_q), 64'd0);
    check("t6_ill_cnt",   64'(ill_cnt), 64'd0);
    check("t6_out_data",  64'(out_data), 64'd0);
    check("t6_in_ready",  {63'd0, in_ready}, 64'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_post_out_valid", {63'd0, out_valid}, 64'd0);

`ifdef EXT_BYPASS_EN
    // Bypass: empty queue forwards the extended input in the same cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'd1;
    in_imm    = 16'h0001;
    exp_q.push_back({1'b0, 32'h00000001});
    #1;
    check("byp_out_valid", {63'd0, out_valid}, 64'd1);
    check("byp_out_data",  64'(out_data), 64'h00000001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("byp_count", 64'(dut.count_q), 64'd0);
    drain("byp_drain");
`endif

    // Final result after reset: push one more through a live queue
    out_ready = 1'b1;
    push_one(3'd1, 16'h7FFF, 32'h00007FFF, 1'b0);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
